// File: rtl/execute_stage_if.sv
// EX stage bus: decode-side operands/control in, EX/MEM pipeline outputs.
// The stage itself connects through the slave modport.
interface execute_stage_if #(
    parameter int WIDTH = 64
);
    logic             flush;
    logic [2:0]       alu_op_EX_in;
    logic             alu_src_sel;
    logic             set_flags;
    logic [1:0]       fwd_a_sel;
    logic [1:0]       fwd_b_sel;
    logic             write_enable_EX_in;
    logic             RegWrite_EX_in;
    logic             memtoreg_sel_EX_in;
    logic [4:0]       WriteRegister_EX_in;
    logic [5:0]       shamt;
    logic [WIDTH-1:0] ReadData1_EX_in;
    logic [WIDTH-1:0] ReadData2_EX_in;
    logic [WIDTH-1:0] imm_EX_in;
    logic [WIDTH-1:0] wb_data_in;
    logic             write_enable_MEM_out;
    logic             RegWrite_MEM_out;
    logic             memtoreg_sel_MEM_out;
    logic [4:0]       WriteRegister_MEM_out;
    logic [WIDTH-1:0] alu_result_MEM_out;
    logic [WIDTH-1:0] ReadData2_MEM_out;
    logic [3:0]       flags_out;
    logic [3:0]       flags_fwd;
    logic             zero_EX;

    modport master (
        output flush, alu_op_EX_in, alu_src_sel, set_flags,
        output fwd_a_sel, fwd_b_sel,
        output write_enable_EX_in, RegWrite_EX_in, memtoreg_sel_EX_in,
        output WriteRegister_EX_in, shamt,
        output ReadData1_EX_in, ReadData2_EX_in, imm_EX_in, wb_data_in,
        input  write_enable_MEM_out, RegWrite_MEM_out, memtoreg_sel_MEM_out,
        input  WriteRegister_MEM_out, alu_result_MEM_out, ReadData2_MEM_out,
        input  flags_out, flags_fwd, zero_EX
    );

    modport slave (
        input  flush, alu_op_EX_in, alu_src_sel, set_flags,
        input  fwd_a_sel, fwd_b_sel,
        input  write_enable_EX_in, RegWrite_EX_in, memtoreg_sel_EX_in,
        input  WriteRegister_EX_in, shamt,
        input  ReadData1_EX_in, ReadData2_EX_in, imm_EX_in, wb_data_in,
        output write_enable_MEM_out, RegWrite_MEM_out, memtoreg_sel_MEM_out,
        output WriteRegister_MEM_out, alu_result_MEM_out, ReadData2_MEM_out,
        output flags_out, flags_fwd, zero_EX
    );
endinterface

// File: rtl/execute_stage.sv
// Execute stage: operand forwarding, ALU/shifter, NZCV register,
// and the EX/MEM pipeline register with flush-to-bubble.
module execute_stage #(
    parameter int WIDTH = 64
) (
    input  logic          clk,
    input  logic          reset,
    execute_stage_if.slave bus
);
    localparam logic [2:0] OP_PASS = 3'b000;
    localparam logic [2:0] OP_LSL  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_AND  = 3'b100;
    localparam logic [2:0] OP_ORR  = 3'b101;
    localparam logic [2:0] OP_EOR  = 3'b110;
    localparam logic [2:0] OP_LSR  = 3'b111;

    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] fwd_b;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum;
    logic             is_sub;
    logic [WIDTH-1:0] res_d, res_q;
    logic [WIDTH-1:0] rd2_q;
    logic             c_new, v_new;
    logic [3:0]       flags_d, flags_q;
    logic             we_q, rw_q, mt_q;
    logic [4:0]       wr_q;

    // Forwarding muxes: path 01 is this stage's own registered result.
    always_comb begin
        op_a  = bus.ReadData1_EX_in;
        fwd_b = bus.ReadData2_EX_in;
        unique case (bus.fwd_a_sel)
            2'b01:   op_a = res_q;
            2'b10:   op_a = bus.wb_data_in;
            default: op_a = bus.ReadData1_EX_in;
        endcase
        unique case (bus.fwd_b_sel)
            2'b01:   fwd_b = res_q;
            2'b10:   fwd_b = bus.wb_data_in;
            default: fwd_b = bus.ReadData2_EX_in;
        endcase
        op_b = bus.alu_src_sel ? bus.imm_EX_in : fwd_b;
    end

    // ALU: one shared adder serves ADD and SUB (invert B, carry in 1).
    always_comb begin
        is_sub = (bus.alu_op_EX_in == OP_SUB);
        b_eff  = is_sub ? ~op_b : op_b;
        sum    = {1'b0, op_a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};
        res_d  = op_b;
        c_new  = 1'b0;
        v_new  = 1'b0;
        unique case (bus.alu_op_EX_in)
            OP_PASS: res_d = op_b;
            OP_LSL:  res_d = op_a << bus.shamt;
            OP_ADD, OP_SUB: begin
                res_d = sum[WIDTH-1:0];
                c_new = sum[WIDTH];
                v_new = (op_a[WIDTH-1] == b_eff[WIDTH-1]) &&
                        (sum[WIDTH-1] != op_a[WIDTH-1]);
            end
            OP_AND:  res_d = op_a & op_b;
            OP_ORR:  res_d = op_a | op_b;
            OP_EOR:  res_d = op_a ^ op_b;
            OP_LSR:  res_d = op_a >> bus.shamt;
            default: res_d = op_b;
        endcase
        flags_d = {res_d[WIDTH-1], (res_d == '0), c_new, v_new};
    end

    // EX/MEM register; flush zeroes control and freezes the flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            res_q   <= '0;
            rd2_q   <= '0;
            flags_q <= '0;
            we_q    <= 1'b0;
            rw_q    <= 1'b0;
            mt_q    <= 1'b0;
            wr_q    <= '0;
        end else begin
            res_q <= res_d;
            rd2_q <= fwd_b;
            wr_q  <= bus.WriteRegister_EX_in;
            we_q  <= bus.write_enable_EX_in & ~bus.flush;
            rw_q  <= bus.RegWrite_EX_in & ~bus.flush;
            mt_q  <= bus.memtoreg_sel_EX_in & ~bus.flush;
            if (bus.set_flags && !bus.flush)
                flags_q <= flags_d;
        end
    end

    assign bus.alu_result_MEM_out    = res_q;
    assign bus.ReadData2_MEM_out     = rd2_q;
    assign bus.flags_out             = flags_q;
    assign bus.write_enable_MEM_out  = we_q;
    assign bus.RegWrite_MEM_out      = rw_q;
    assign bus.memtoreg_sel_MEM_out  = mt_q;
    assign bus.WriteRegister_MEM_out = wr_q;
    assign bus.flags_fwd             = bus.set_flags ? flags_d : flags_q;
    assign bus.zero_EX               = (fwd_b == '0);
endmodule

// File: doc/execute_stage.md
# execute_stage

Execute (EX) stage of the pipelined 64-bit ARM CPU, sitting between decode and the memory stage. It forwards operands, performs the ALU or shift operation, and maintains the NZCV flag register. It registers the result and the passthrough control into the EX/MEM pipeline outputs that drive the memory stage directly. It supports pipeline flush, which inserts a bubble.

## Interface
Parameters:
- WIDTH, 64, datapath width; only 64 is verified.

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; clears every register
- flush  in  1  bubble-insert: zero the control outputs at the next edge
- alu_op_EX_in  in  3  000 pass B, 001 LSL, 010 ADD, 011 SUB, 100 AND, 101 ORR, 110 EOR, 111 LSR
- alu_src_sel  in  1  0: operand B = forwarded ReadData2; 1: operand B = imm_EX_in
- set_flags  in  1  update NZCV this instruction
- fwd_a_sel, fwd_b_sel  in  2  00 decode value, 01 alu_result_MEM_out, 10 wb_data_in, 11 same as 00
- write_enable_EX_in, RegWrite_EX_in, memtoreg_sel_EX_in  in  1  control passed to MEM
- WriteRegister_EX_in  in  5  destination register
- shamt  in  6  shift amount for LSL/LSR
- ReadData1_EX_in, ReadData2_EX_in, imm_EX_in, wb_data_in  in  64  operands, immediate, WB-stage result
- write_enable_MEM_out, RegWrite_MEM_out, memtoreg_sel_MEM_out  out  1  registered control
- WriteRegister_MEM_out  out  5  registered destination
- alu_result_MEM_out, ReadData2_MEM_out  out  64  registered ALU result; registered forwarded store data
- flags_out  out  4  registered {N,Z,C,V}
- flags_fwd  out  4  {N,Z,C,V} for the current cycle's branch decision (see Operation)
- zero_EX  out  1  combinational: forwarded operand B == 0 (CBZ)

## Operation
- Operand A: fwd_a_sel picks ReadData1_EX_in, alu_result_MEM_out, or wb_data_in.
- Forwarded B is chosen the same way with fwd_b_sel.
- Operand B is the forwarded B, or imm_EX_in when alu_src_sel = 1.
- ALU result:
  - ADD: A+B.
  - SUB: A+~B+1.
  - Logic ops: bitwise.
  - LSL/LSR: A shifted by shamt, zero fill; shamt 0 passes A.
  - Pass B: returns operand B.
- New flags:
  - N = result[63]; Z = (result == 0).
  - ADD/SUB: C = carry out of bit 63 (SUB: 1 means no borrow); V = signed overflow (operand signs equal after B inversion, result sign differs).
  - All other ops: C = V = 0.
- flags_fwd = new flags when set_flags = 1, else flags_out.
- ReadData2_MEM_out captures the forwarded B before the immediate mux, so stores see the forwarded data.
- Every output register loads on each edge; there is no stall (stall is handled upstream as a flush).
- Flush:
  - Next edge loads 0 into write_enable, RegWrite and memtoreg; data registers load normally.
  - The flag register does not update, even if set_flags = 1.
- Flag register loads the new flags only when set_flags = 1 and flush = 0.

## Timing
- One-cycle latency: inputs at edge k appear on the *_MEM_out outputs after edge k.
- flags_fwd and zero_EX are combinational within the cycle.
- Reset (asynchronous, active-high):
  - All *_MEM_out = 0 and flags_out = 0000 immediately, held while reset = 1.
  - The first capture is at the first edge after reset falls.
- Reset asserted mid-instruction discards the instruction; no partial flag update.
- Forward path 01 uses this block's own registered output, so back-to-back dependent instructions resolve with zero bubbles.
- Simultaneous flush and set_flags: flush wins.
- Add/sub wrap modulo 2^64.

## Test plan
- Reset mid-run: assert reset between edges with nonzero outputs -> all outputs 0 before the next edge; flags_out = 0000.
- ADD with flags: A = 0x7FFF_FFFF_FFFF_FFFF, B = 1, set_flags -> alu_result_MEM_out = 0x8000_0000_0000_0000, flags_out = N1 Z0 C0 V1 one edge later; flags_fwd shows this in the issue cycle.
- SUB equal: A = B = 5, set_flags -> result 0, NZCV = 0110; following ADD without set_flags leaves flags_out = 0110.
- Forwarding chain: ADD X1 = 3+4, then ADD with fwd_a_sel = 01, imm 10 -> second result 17; fwd_b_sel = 10 with wb_data_in = 0x55, ORR with 0xAA -> 0xFF.
- Flush: RegWrite = 1, write_enable = 1, set_flags = 1, flush = 1 -> next edge RegWrite_MEM_out = 0, write_enable_MEM_out = 0, flags_out unchanged.
- Shifts and CBZ:
  - LSL of 1 by 63 -> 0x8000_0000_0000_0000.
  - LSR of that by 63 -> 1.
  - Forwarded B = 0 -> zero_EX = 1 the same cycle.
  - Store with forwarded B = 0x1234 and alu_src_sel = 1 -> ReadData2_MEM_out = 0x1234.
